// File: rtl/z88_sram_arbiter.sv
// Slot-0 SRAM arbiter: the CPU has combinational priority and the LCD fetcher reads in free cycles.
// Optional macro SRAM_WAIT_EN: a CPU access during a video read stalls the CPU instead of aborting the read.
module z88_sram_arbiter #(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_ce_n,
  input  logic          cpu_oe_n,
  input  logic          cpu_we_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_do,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          ram_ce_n,
  output logic          ram_oe_n,
  output logic          ram_we_n
);

  typedef enum logic [1:0] {IDLE, VRD, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          vid_ack_q, vid_ack_d;
  logic [DW-1:0] vid_data_q, vid_data_d;

  logic cpu_own;
  logic vid_own;
  logic cpu_stall;
  logic vid_abort;

`ifdef SRAM_WAIT_EN
  // A CPU access arriving mid-read waits for the video read to finish.
  assign cpu_stall = (state_q == VRD) && !cpu_ce_n;
  assign vid_abort = 1'b0;
  assign cpu_own   = reset_n && !cpu_ce_n && (state_q != VRD);
`else
  assign cpu_stall = 1'b0;
  assign vid_abort = !cpu_ce_n;
  assign cpu_own   = reset_n && !cpu_ce_n;
`endif

  assign vid_own    = reset_n && !cpu_own && (state_q == VRD);
  assign cpu_wait_n = !cpu_stall;
  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;
  assign cpu_di     = cpu_own ? ram_do : '1;

  always_comb begin
    ram_a    = '0;
    ram_di   = '0;
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    if (cpu_own) begin
      ram_a    = cpu_a;
      ram_di   = cpu_do;
      ram_ce_n = 1'b0;
      ram_oe_n = cpu_oe_n;
      ram_we_n = cpu_we_n;
    end else if (vid_own) begin
      ram_a    = vid_a;
      ram_ce_n = 1'b0;
      ram_oe_n = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vid_ack_d  = 1'b0;
    vid_data_d = vid_data_q;
    case (state_q)
      IDLE: begin
        if (vid_req && cpu_ce_n) begin
          state_d = VRD;
          cnt_d   = CNT_LOAD;
        end
      end
      VRD: begin
        if (vid_abort) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          // The read completes even if the requester dropped vid_req early.
          vid_data_d = ram_do;
          vid_ack_d  = 1'b1;
          state_d    = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      vid_ack_q  <= 1'b0;
      vid_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vid_ack_q  <= vid_ack_d;
      vid_data_q <= vid_data_d;
    end
  end

endmodule

// File: tb/tb_z88_sram_arbiter.sv
// Directed bench for z88_sram_arbiter (ACC_CYC = 2); collision expectations follow SRAM_WAIT_EN.
module tb_z88_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ce_n, cpu_oe_n, cpu_we_n;
  logic [18:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [18:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic [18:0] ram_a;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  int compared   = 0;
  int mismatched = 0;

  z88_sram_arbiter #(.AW(19), .DW(8), .ACC_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_data(vid_data),
    .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ce_n, input logic oe_n, input logic we_n,
                               input logic [18:0] a, input logic [7:0] d,
                               input logic req, input logic [18:0] va, input logic [7:0] rdo);
    cpu_ce_n = ce_n;
    cpu_oe_n = oe_n;
    cpu_we_n = we_n;
    cpu_a    = a;
    cpu_do   = d;
    vid_req  = req;
    vid_a    = va;
    ram_do   = rdo;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, ".ce_n"}, 32'(ram_ce_n), 32'h1);
    checkOutput({tag, ".oe_n"}, 32'(ram_oe_n), 32'h1);
    checkOutput({tag, ".we_n"}, 32'(ram_we_n), 32'h1);
  endtask

  task automatic checkVideoBus(input string tag, input logic [18:0] a);
    checkOutput({tag, ".ce_n"}, 32'(ram_ce_n), 32'h0);
    checkOutput({tag, ".oe_n"}, 32'(ram_oe_n), 32'h0);
    checkOutput({tag, ".we_n"}, 32'(ram_we_n), 32'h1);
    checkOutput({tag, ".ram_a"}, 32'(ram_a), 32'(a));
  endtask

  initial begin
    // Reset with a pending video request
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h7FFFF, 8'h99);
    tick();
    tick();
    checkIdleBus("rst");
    checkOutput("rst.ram_a", 32'(ram_a), 32'h0);
    checkOutput("rst.ram_di", 32'(ram_di), 32'h0);
    checkOutput("rst.vid_ack", 32'(vid_ack), 32'h0);
    checkOutput("rst.vid_data", 32'(vid_data), 32'h0);
    checkOutput("rst.wait_n", 32'(cpu_wait_n), 32'h1);
    checkOutput("rst.cpu_di", 32'(cpu_di), 32'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h0, 8'h99);
    reset_n = 1'b1;
    tick();
    checkIdleBus("idle");

    // Plain video read: VRD, VRD, ACK
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h12345, 8'h5A);
    checkIdleBus("vr.c0");
    tick();
    checkVideoBus("vr.c1", 19'h12345);
    checkOutput("vr.c1.ack", 32'(vid_ack), 32'h0);
    tick();
    checkVideoBus("vr.c2", 19'h12345);
    checkOutput("vr.c2.ack", 32'(vid_ack), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h12345, 8'h00);
    checkOutput("vr.c3.ack", 32'(vid_ack), 32'h1);
    checkOutput("vr.c3.data", 32'(vid_data), 32'h5A);
    checkIdleBus("vr.c3");
    tick();
    checkOutput("vr.c4.ack", 32'(vid_ack), 32'h0);
    checkOutput("vr.c4.data", 32'(vid_data), 32'h5A);

    // CPU write while idle: zero-latency pass-through
    applyStimulus(1'b0, 1'b1, 1'b0, 19'h00100, 8'hA5, 1'b0, 19'h0, 8'h77);
    checkOutput("cw.ram_a", 32'(ram_a), 32'h00100);
    checkOutput("cw.ram_di", 32'(ram_di), 32'hA5);
    checkOutput("cw.ce_n", 32'(ram_ce_n), 32'h0);
    checkOutput("cw.oe_n", 32'(ram_oe_n), 32'h1);
    checkOutput("cw.we_n", 32'(ram_we_n), 32'h0);
    checkOutput("cw.cpu_di", 32'(cpu_di), 32'h77);
    tick();
    checkOutput("cw.ack", 32'(vid_ack), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h00100, 8'hA5, 1'b0, 19'h0, 8'h77);
    checkOutput("cw.rel.cpu_di", 32'(cpu_di), 32'hFF);
    checkIdleBus("cw.rel");
    tick();

    // CPU and video request together in IDLE: CPU wins, no read starts
    applyStimulus(1'b0, 1'b0, 1'b1, 19'h00042, 8'h00, 1'b1, 19'h55555, 8'h31);
    checkOutput("tie.ram_a", 32'(ram_a), 32'h00042);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h00042, 8'h00, 1'b0, 19'h55555, 8'h31);
    checkIdleBus("tie.c1");
    tick();

    // Collision: CPU read asserted in the first VRD clock for three clocks
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h0ABCD, 8'h3C);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 19'h00200, 8'h00, 1'b1, 19'h0ABCD, 8'h3C);
`ifdef SRAM_WAIT_EN
    checkVideoBus("col.c1", 19'h0ABCD);
    checkOutput("col.c1.wait_n", 32'(cpu_wait_n), 32'h0);
    checkOutput("col.c1.cpu_di", 32'(cpu_di), 32'hFF);
    tick();
    checkVideoBus("col.c2", 19'h0ABCD);
    checkOutput("col.c2.wait_n", 32'(cpu_wait_n), 32'h0);
    tick();
    checkOutput("col.c3.ack", 32'(vid_ack), 32'h1);
    checkOutput("col.c3.data", 32'(vid_data), 32'h3C);
    checkOutput("col.c3.wait_n", 32'(cpu_wait_n), 32'h1);
    checkOutput("col.c3.ram_a", 32'(ram_a), 32'h00200);
    checkOutput("col.c3.cpu_di", 32'(cpu_di), 32'h3C);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h0, 8'h00);
    checkOutput("col.c4.ack", 32'(vid_ack), 32'h0);
    checkIdleBus("col.c4");
    tick();
`else
    checkOutput("col.c1.ram_a", 32'(ram_a), 32'h00200);
    checkOutput("col.c1.ce_n", 32'(ram_ce_n), 32'h0);
    checkOutput("col.c1.wait_n", 32'(cpu_wait_n), 32'h1);
    checkOutput("col.c1.cpu_di", 32'(cpu_di), 32'h3C);
    tick();
    checkOutput("col.c2.ack", 32'(vid_ack), 32'h0);
    checkOutput("col.c2.ram_a", 32'(ram_a), 32'h00200);
    tick();
    checkOutput("col.c3.ack", 32'(vid_ack), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h0ABCD, 8'h3C);
    checkIdleBus("col.c4");
    checkOutput("col.c4.ack", 32'(vid_ack), 32'h0);
    tick();
    checkVideoBus("col.c5", 19'h0ABCD);
    tick();
    checkVideoBus("col.c6", 19'h0ABCD);
    checkOutput("col.c6.ack", 32'(vid_ack), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h0, 8'h00);
    checkOutput("col.c7.ack", 32'(vid_ack), 32'h1);
    checkOutput("col.c7.data", 32'(vid_data), 32'h3C);
    tick();
`endif

    // Back-to-back fetches with vid_req held high
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h11111, 8'h11);
    tick();
    checkVideoBus("b2b.c1", 19'h11111);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h22222, 8'h22);
    checkOutput("b2b.c3.ack", 32'(vid_ack), 32'h1);
    checkOutput("b2b.c3.data", 32'(vid_data), 32'h11);
    tick();
    checkOutput("b2b.c4.ack", 32'(vid_ack), 32'h0);
    checkIdleBus("b2b.c4");
    tick();
    checkVideoBus("b2b.c5", 19'h22222);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h0, 8'h00);
    checkOutput("b2b.c7.ack", 32'(vid_ack), 32'h1);
    checkOutput("b2b.c7.data", 32'(vid_data), 32'h22);
    tick();

    // Requester drops vid_req early: read still completes with an ack
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h03030, 8'hC3);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h03030, 8'hC3);
    checkVideoBus("drop.c1", 19'h03030);
    tick();
    tick();
    checkOutput("drop.c3.ack", 32'(vid_ack), 32'h1);
    checkOutput("drop.c3.data", 32'(vid_data), 32'hC3);
    tick();

    // Asynchronous reset in the middle of a video read
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b1, 19'h04444, 8'hE7);
    tick();
    checkVideoBus("mrst.c1", 19'h04444);
    reset_n = 1'b0;
    #1;
    checkIdleBus("mrst");
    checkOutput("mrst.ram_a", 32'(ram_a), 32'h0);
    checkOutput("mrst.data", 32'(vid_data), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h0, 8'h00, 1'b0, 19'h0, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("mrst.ack", 32'(vid_ack), 32'h0);
    checkIdleBus("mrst.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
